// File: rtl/mem_pkg.sv
// Memory-side types shared by memory clients and arbiters.
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_ACCESS_BYTE = 2'd0,
    MEM_ACCESS_HALF = 2'd1,
    MEM_ACCESS_WORD = 2'd2
  } mem_access_t;

  typedef logic [3:0] mem_exception_mask_t;

endpackage

// File: rtl/mem_port_arbiter_pkg.sv
// Types for the two-requester memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN0 = 2'd1,
    S_OWN1 = 2'd2
  } arb_state_t;

  typedef enum logic {
    ARB_M0 = 1'b0,
    ARB_M1 = 1'b1
  } arb_id_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side bundle of the memory port arbiter.
interface mem_port_arbiter_if;
  import mem_pkg::*;

  logic                req;
  logic                lock;
  logic [31:0]         addr;
  logic [31:0]         wr_data;
  logic                wr_ena;
  mem_access_t         access;
  logic                gnt;
  logic                rd_valid;
  logic [31:0]         rd_data;
  mem_exception_mask_t exception;

  modport master (
    output req, lock, addr, wr_data, wr_ena, access,
    input  gnt, rd_valid, rd_data, exception
  );

  modport slave (
    input  req, lock, addr, wr_data, wr_ena, access,
    output gnt, rd_valid, rd_data, exception
  );

endinterface

// File: rtl/arb_rr_pick.sv
// Two-way winner select: round-robin on last grant, or m0-first.
module arb_rr_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int RR_EN = 1
) (
  input  logic    i_req0,
  input  logic    i_req1,
  input  arb_id_t i_last,
  output logic    o_pick0,
  output logic    o_pick1
);

  logic w_m1_first;

  assign w_m1_first = (RR_EN != 0) && (i_last == ARB_M0);
  assign o_pick0    = i_req0 && !(i_req1 && w_m1_first);
  assign o_pick1    = i_req1 && !(i_req0 && !w_m1_first);

endmodule

// File: rtl/mem_port_arbiter.sv
// Core/DMA memory port arbiter with lock ownership.
// Define MEM_PORT_ARBITER_STATS_EN for grant/contention counters.
module mem_port_arbiter
  import mem_pkg::*;
  import mem_port_arbiter_pkg::*;
#(
  parameter int RR_EN = 1
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   m0,
  mem_port_arbiter_if.slave   m1,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_wr_data,
  output logic                mem_wr_ena,
  output mem_access_t         mem_access,
  input  logic [31:0]         mem_rd_data,
  input  mem_exception_mask_t mem_exception
`ifdef MEM_PORT_ARBITER_STATS_EN
  ,
  output logic [31:0]         grants0,
  output logic [31:0]         grants1,
  output logic [31:0]         contention_cycles
`endif
);

  arb_state_t r_state;
  arb_id_t    r_last;
  logic       r_pend0;
  logic       r_pend1;
  logic       r_pend_lock;

  logic w_pick0, w_pick1;
  logic w_gnt0, w_gnt1;
  logic w_rv0, w_rv1;
  logic w_exc_abort;

  arb_rr_pick #(.RR_EN(RR_EN)) u_pick (
    .i_req0  (m0.req),
    .i_req1  (m1.req),
    .i_last  (r_last),
    .o_pick0 (w_pick0),
    .o_pick1 (w_pick1)
  );

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_gnt0 = w_pick0;
        w_gnt1 = w_pick1;
      end
      S_OWN0:  w_gnt0 = m0.req;
      S_OWN1:  w_gnt1 = m1.req;
      default: ;
    endcase
    if (rst) begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end
  end

  // A faulting access inside an atomic sequence breaks the lock.
  assign w_exc_abort = r_pend_lock && (mem_exception != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_last      <= ARB_M1;
      r_pend0     <= 1'b0;
      r_pend1     <= 1'b0;
      r_pend_lock <= 1'b0;
    end else begin
      r_pend0     <= w_gnt0;
      r_pend1     <= w_gnt1;
      r_pend_lock <= (w_gnt0 && m0.lock) ||
                     (w_gnt1 && m1.lock);
      if (w_gnt0)
        r_last <= ARB_M0;
      else if (w_gnt1)
        r_last <= ARB_M1;
      if (w_exc_abort) begin
        r_state <= S_IDLE;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (w_gnt0 && m0.lock)
              r_state <= S_OWN0;
            else if (w_gnt1 && m1.lock)
              r_state <= S_OWN1;
          end
          S_OWN0:  r_state <= m0.lock ? S_OWN0 : S_IDLE;
          S_OWN1:  r_state <= m1.lock ? S_OWN1 : S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    mem_addr    = '0;
    mem_wr_data = '0;
    mem_wr_ena  = 1'b0;
    mem_access  = MEM_ACCESS_WORD;
    if (w_gnt0) begin
      mem_addr    = m0.addr;
      mem_wr_data = m0.wr_data;
      mem_wr_ena  = m0.wr_ena;
      mem_access  = m0.access;
    end else if (w_gnt1) begin
      mem_addr    = m1.addr;
      mem_wr_data = m1.wr_data;
      mem_wr_ena  = m1.wr_ena;
      mem_access  = m1.access;
    end
  end

  assign w_rv0 = r_pend0 && !rst;
  assign w_rv1 = r_pend1 && !rst;

  assign m0.gnt       = w_gnt0;
  assign m0.rd_valid  = w_rv0;
  assign m0.rd_data   = w_rv0 ? mem_rd_data : '0;
  assign m0.exception = w_rv0 ? mem_exception : '0;

  assign m1.gnt       = w_gnt1;
  assign m1.rd_valid  = w_rv1;
  assign m1.rd_data   = w_rv1 ? mem_rd_data : '0;
  assign m1.exception = w_rv1 ? mem_exception : '0;

`ifdef MEM_PORT_ARBITER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grants0           <= '0;
      grants1           <= '0;
      contention_cycles <= '0;
    end else begin
      if (w_gnt0)
        grants0 <= grants0 + 32'd1;
      if (w_gnt1)
        grants1 <= grants1 + 32'd1;
      if (m0.req && m1.req)
        contention_cycles <= contention_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (RR and fixed-priority builds).
module tb_mem_port_arbiter;
  import mem_pkg::*;
  import mem_port_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if m0 ();
  mem_port_arbiter_if m1 ();
  mem_port_arbiter_if f0 ();
  mem_port_arbiter_if f1 ();

  logic [31:0]         mem_addr, mem_wr_data;
  logic                mem_wr_ena;
  mem_access_t         mem_access;
  logic [31:0]         f_addr, f_wr_data;
  logic                f_wr_ena;
  mem_access_t         f_access;
  logic [31:0]         mem_rd_data;
  mem_exception_mask_t mem_exception;
`ifdef MEM_PORT_ARBITER_STATS_EN
  logic [31:0] g0, g1, cc, fg0, fg1, fcc;
`endif

  assign f0.req     = m0.req;
  assign f0.lock    = m0.lock;
  assign f0.addr    = m0.addr;
  assign f0.wr_data = m0.wr_data;
  assign f0.wr_ena  = m0.wr_ena;
  assign f0.access  = m0.access;
  assign f1.req     = m1.req;
  assign f1.lock    = m1.lock;
  assign f1.addr    = m1.addr;
  assign f1.wr_data = m1.wr_data;
  assign f1.wr_ena  = m1.wr_ena;
  assign f1.access  = m1.access;

  mem_port_arbiter #(.RR_EN(1)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .m0            (m0),
    .m1            (m1),
    .mem_addr      (mem_addr),
    .mem_wr_data   (mem_wr_data),
    .mem_wr_ena    (mem_wr_ena),
    .mem_access    (mem_access),
    .mem_rd_data   (mem_rd_data),
    .mem_exception (mem_exception)
`ifdef MEM_PORT_ARBITER_STATS_EN
    ,
    .grants0           (g0),
    .grants1           (g1),
    .contention_cycles (cc)
`endif
  );

  mem_port_arbiter #(.RR_EN(0)) u_fp (
    .clk           (clk),
    .rst           (rst),
    .m0            (f0),
    .m1            (f1),
    .mem_addr      (f_addr),
    .mem_wr_data   (f_wr_data),
    .mem_wr_ena    (f_wr_ena),
    .mem_access    (f_access),
    .mem_rd_data   (mem_rd_data),
    .mem_exception (mem_exception)
`ifdef MEM_PORT_ARBITER_STATS_EN
    ,
    .grants0           (fg0),
    .grants1           (fg1),
    .contention_cycles (fcc)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               tag, got, exp);
  endtask

  task automatic drv0(input logic req, lock, wr,
                      input logic [31:0] a, d);
    m0.req     = req;
    m0.lock    = lock;
    m0.wr_ena  = wr;
    m0.addr    = a;
    m0.wr_data = d;
    m0.access  = MEM_ACCESS_WORD;
  endtask

  task automatic drv1(input logic req, lock, wr,
                      input logic [31:0] a, d);
    m1.req     = req;
    m1.lock    = lock;
    m1.wr_ena  = wr;
    m1.addr    = a;
    m1.wr_data = d;
    m1.access  = MEM_ACCESS_WORD;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [5:0] rr_g0;

  initial begin
    rst = 1'b1;
    drv0(0, 0, 0, 0, 0);
    drv1(0, 0, 0, 0, 0);
    mem_rd_data   = '0;
    mem_exception = '0;
    tick;
    drv0(1, 0, 0, 32'h55, 0);
    drv1(1, 0, 0, 32'h66, 0);
    #2;
    check("rst_gnt0", m0.gnt, 0);
    check("rst_gnt1", m1.gnt, 0);
    check("rst_rdv0", m0.rd_valid, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wena", mem_wr_ena, 0);
    check("rst_acc", 32'(mem_access), 2);
    drv0(0, 0, 0, 0, 0);
    drv1(0, 0, 0, 0, 0);
    rst = 1'b0;
    tick;

    // single m0 load
    drv0(1, 0, 0, 32'h1000_0000, 0);
    #2;
    check("ld_gnt0", m0.gnt, 1);
    check("ld_gnt1", m1.gnt, 0);
    check("ld_addr", mem_addr, 32'h1000_0000);
    check("ld_wena", mem_wr_ena, 0);
    tick;
    drv0(0, 0, 0, 0, 0);
    mem_rd_data = 32'hCAFE_BABE;
    #2;
    check("ld_rdv0", m0.rd_valid, 1);
    check("ld_rdat0", m0.rd_data, 32'hCAFE_BABE);
    check("ld_rdv1", m1.rd_valid, 0);
    check("ld_rdat1", m1.rd_data, 0);
    check("idle_addr", mem_addr, 0);
    check("idle_gnt0", m0.gnt, 0);

    // contention after fresh reset
    rst = 1'b1;
    tick;
    rst = 1'b0;
    mem_rd_data = 32'h1234_5678;
    drv0(1, 0, 0, 32'h100, 0);
    drv1(1, 0, 0, 32'h200, 0);
    rr_g0 = 6'b010101;
    for (int i = 0; i < 6; i++) begin
      #2;
      check("rr_gnt0", m0.gnt, rr_g0[i]);
      check("rr_gnt1", m1.gnt, !rr_g0[i]);
      check("rr_addr", mem_addr,
            rr_g0[i] ? 32'h100 : 32'h200);
      check("fp_gnt0", f0.gnt, 1);
      check("fp_gnt1", f1.gnt, 0);
      if (i > 0) begin
        check("rr_rdv0", m0.rd_valid, rr_g0[i-1]);
        check("rr_rdv1", m1.rd_valid, !rr_g0[i-1]);
      end
      tick;
    end
    drv0(0, 0, 0, 0, 0);
    drv1(0, 0, 0, 0, 0);

    // locked m1 stores while m0 waits
    drv0(1, 0, 0, 32'h300, 0);
    #2;
    check("lk_pre0", m0.gnt, 1);
    tick;
    drv0(1, 0, 0, 32'h400, 0);
    drv1(1, 1, 1, 32'h500, 32'hD1);
    #2;
    check("lk1_gnt1", m1.gnt, 1);
    check("lk1_gnt0", m0.gnt, 0);
    check("lk1_wena", mem_wr_ena, 1);
    check("lk1_wdat", mem_wr_data, 32'hD1);
    check("lk1_addr", mem_addr, 32'h500);
    tick;
    drv1(1, 1, 1, 32'h504, 32'hD2);
    #2;
    check("lk2_gnt1", m1.gnt, 1);
    check("lk2_gnt0", m0.gnt, 0);
    check("lk2_rdv1", m1.rd_valid, 1);
    check("lk2_wdat", mem_wr_data, 32'hD2);
    tick;
    drv1(1, 0, 1, 32'h508, 32'hD3);
    #2;
    check("lk3_gnt1", m1.gnt, 1);
    check("lk3_gnt0", m0.gnt, 0);
    tick;
    drv1(0, 0, 0, 0, 0);
    #2;
    check("lk4_gnt0", m0.gnt, 1);
    check("lk4_addr", mem_addr, 32'h400);
    check("lk4_rdv1", m1.rd_valid, 1);
    tick;

    // exception on a locked m0 access
    drv0(1, 1, 0, 32'h600, 0);
    #2;
    check("ex_gnt0", m0.gnt, 1);
    tick;
    drv0(0, 1, 0, 0, 0);
    drv1(1, 0, 0, 32'h700, 0);
    mem_exception = 4'b0010;
    #2;
    check("ex_rdv0", m0.rd_valid, 1);
    check("ex_exc0", 32'(m0.exception), 2);
    check("ex_exc1", 32'(m1.exception), 0);
    check("ex_own_g1", m1.gnt, 0);
    tick;
    mem_exception = '0;
    #2;
    check("ex_idle_g1", m1.gnt, 1);
    check("ex_addr", mem_addr, 32'h700);
    tick;
    drv0(0, 0, 0, 0, 0);
    drv1(0, 0, 0, 0, 0);

    // asynchronous reset while m1 owns the port
    drv1(1, 1, 0, 32'h800, 0);
    #2;
    check("ar_gnt1a", m1.gnt, 1);
    tick;
    drv1(1, 1, 0, 32'h804, 0);
    #2;
    check("ar_gnt1b", m1.gnt, 1);
    check("ar_rdv1b", m1.rd_valid, 1);
    #1;
    rst = 1'b1;
    #1;
    check("ar_rst_g1", m1.gnt, 0);
    check("ar_rst_rv", m1.rd_valid, 0);
    check("ar_rst_ad", mem_addr, 0);
    tick;
    tick;
    rst = 1'b0;
    drv0(1, 0, 0, 32'h900, 0);
    drv1(1, 0, 0, 32'h904, 0);
    #2;
    check("ar_rel_g0", m0.gnt, 1);
    check("ar_rel_g1", m1.gnt, 0);
    check("ar_rel_rv", m1.rd_valid, 0);
    tick;
    drv0(0, 0, 0, 0, 0);
    drv1(0, 0, 0, 0, 0);

`ifdef MEM_PORT_ARBITER_STATS_EN
    rst = 1'b1;
    tick;
    #2;
    check("st_rst_g0", g0, 0);
    check("st_rst_cc", cc, 0);
    rst = 1'b0;
    drv0(1, 0, 0, 32'h10, 0);
    drv1(1, 0, 0, 32'h20, 0);
    tick;
    tick;
    drv1(0, 0, 0, 0, 0);
    repeat (4) tick;
    drv0(0, 0, 0, 0, 0);
    drv1(1, 0, 0, 32'h20, 0);
    repeat (2) tick;
    drv1(0, 0, 0, 0, 0);
    #2;
    check("st_g0", g0, 5);
    check("st_g1", g1, 3);
    check("st_cc", cc, 2);
    check("st_fg0", fg0, 6);
    check("st_fg1", fg1, 2);
    check("st_fcc", fcc, 2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
